// File: rtl/cpu_pkg.sv
// Shared constants and fetch FSM state encoding for the CPU front end.
package cpu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned QDEPTH = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry FIFO of fetched {instruction, address} pairs with flush.
// Head outputs hold the last presented value while the queue is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned QDEPTH = cpu_pkg::QDEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc
);

  logic [DATA_W-1:0] data_mem [QDEPTH];
  logic [ADDR_W-1:0] pc_mem   [QDEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_q;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_pc;
  logic              do_push;
  logic              do_pop;

  assign head_valid = (count_q != 2'd0);
  assign do_push    = push && (count_q < 2'(QDEPTH));
  assign do_pop     = pop && head_valid;
  assign count      = count_q;
  assign head_data  = head_valid ? data_mem[rd_ptr] : hold_data;
  assign head_pc    = head_valid ? pc_mem[rd_ptr]   : hold_pc;

  // Storage, pointers and occupancy; flush empties the queue and wins over push/pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Remember the head shown to decode so the outputs stay put once empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_data <= '0;
      hold_pc   <= '0;
    end else if (head_valid) begin
      hold_data <= data_mem[rd_ptr];
      hold_pc   <= pc_mem[rd_ptr];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues one outstanding memory read at a time for the
// current PC, queues responses for decode, and discards wrong-path fetches.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned QDEPTH = cpu_pkg::QDEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic              halt,
  output logic              pc_advance,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic              halt_latched;
  logic [ADDR_W-1:0] req_pc;
  logic [1:0]        q_count;
  logic              q_push;
  logic              q_pop;
  logic              in_flight;
  logic              has_space;

  assign in_flight = (state == WAIT) || (state == DRAIN);
  assign has_space = ({1'b0, q_count} + {2'b00, in_flight}) < 3'(QDEPTH);
  assign mem_addr  = pc;
  assign halted    = halt_latched && !in_flight;
  assign q_pop     = instr_valid && instr_ready && !redirect;

  // State, halt latch and address of the request currently in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      halt_latched <= 1'b0;
      req_pc       <= '0;
    end else begin
      state        <= state_next;
      halt_latched <= halt_latched | halt;
      if ((state == REQ) && mem_req_ready) begin
        req_pc <= pc;
      end
    end
  end

  // Next-state, request handshake and enqueue decisions.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    pc_advance    = 1'b0;
    q_push        = 1'b0;
    case (state)
      IDLE: begin
        if (halt_latched || halt) begin
          state_next = HALTED;
        end else if (has_space) begin
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          // A request accepted on the redirect cycle is wrong-path: drain its reply.
          if (redirect) begin
            state_next = DRAIN;
          end else begin
            pc_advance = 1'b1;
            state_next = WAIT;
          end
        end else if (halt_latched || halt) begin
          state_next = HALTED;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          q_push     = !redirect;
          state_next = IDLE;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_resp_valid) begin
          state_next = IDLE;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect),
    .push       (q_push),
    .push_data  (mem_resp_data),
    .push_pc    (req_pc),
    .pop        (q_pop),
    .count      (q_count),
    .head_valid (instr_valid),
    .head_data  (instr),
    .head_pc    (instr_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, a memory responder with
// programmable latency, and a transaction-level model of fetched words.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        redirect;
  logic        halt;
  logic        pc_advance;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;

  instr_fetch_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .QDEPTH (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .redirect       (redirect),
    .halt           (halt),
    .pc_advance     (pc_advance),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc = 0;
  int          lat = 2;
  logic [31:0] redirect_tgt = '0;

  // model state
  word_t       dq[$];
  word_t       log_q[$];
  resp_t       pend[$];
  bit          inflight_v = 0;
  bit          inflight_wrong = 0;
  logic [31:0] inflight_pc = '0;
  bit          halt_seen = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_data = '0;

  // sampled outputs of the most recent cycle
  logic s_adv, s_req_valid, s_instr_valid, s_halted;
  logic [31:0] s_instr, s_instr_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] log_pc(input int i);
    if (i < log_q.size()) return {32'b0, log_q[i].pc};
    return '1;
  endfunction

  function automatic logic [63:0] log_data(input int i);
    if (i < log_q.size()) return {32'b0, log_q[i].data};
    return '1;
  endfunction

  // Per-cycle comparison and model update; inputs are stable at this point.
  task automatic model_cycle();
    bit    exp_v;
    bit    hs;
    bit    blocked;
    word_t w;
    exp_v = (dq.size() > 0);
    chk("instr_valid", instr_valid, exp_v);
    if (exp_v) begin
      chk("instr_pc", instr_pc, dq[0].pc);
      chk("instr", instr, dq[0].data);
      last_pc   = dq[0].pc;
      last_data = dq[0].data;
    end else begin
      chk("instr_pc_hold", instr_pc, last_pc);
      chk("instr_hold", instr, last_data);
    end
    hs = mem_req_valid && mem_req_ready;
    chk("pc_advance", pc_advance, hs && !redirect);
    blocked = inflight_v || (dq.size() >= 2) || halt_seen;
    if (blocked) chk("req_blocked", mem_req_valid, 1'b0);
    if (mem_req_valid) chk("mem_addr", mem_addr, pc);
    chk("halted", halted, halt_seen && !inflight_v);

    if (instr_valid && instr_ready && !redirect) log_q.push_back({instr_pc, instr});
    if (exp_v && instr_ready && !redirect) dq.delete(0);
    if (mem_resp_valid && inflight_v) begin
      if (!inflight_wrong && !redirect) begin
        w.pc   = inflight_pc;
        w.data = mem_resp_data;
        dq.push_back(w);
      end
      inflight_v = 0;
    end
    if (redirect) begin
      dq.delete();
      if (inflight_v) inflight_wrong = 1;
    end
    if (hs) begin
      inflight_v     = 1;
      inflight_wrong = redirect;
      inflight_pc    = pc;
      pend.push_back('{data: pc + 32'h100, due: cyc + lat});
    end
    halt_seen = halt_seen | halt;
  endtask

  task automatic model_reset();
    dq.delete();
    inflight_v     = 0;
    inflight_wrong = 0;
    halt_seen      = 0;
    last_pc        = '0;
    last_data      = '0;
  endtask

  // One clock cycle: drive memory reply, check at mid-cycle, move PC at negedge.
  task automatic step();
    logic [31:0] next_pc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = pend[0].data;
      pend.delete(0);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hdead_beef;
    end
    #1;
    s_adv         = pc_advance;
    s_req_valid   = mem_req_valid;
    s_instr_valid = instr_valid;
    s_halted      = halted;
    s_instr       = instr;
    s_instr_pc    = instr_pc;
    next_pc = pc;
    if (reset) begin
      model_cycle();
      if (redirect) next_pc = redirect_tgt;
      else if (s_adv) next_pc = pc + 32'd1;
    end else begin
      model_reset();
    end
    @(negedge clock);
    pc = next_pc;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    reset    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    run(2);
    for (int i = 0; i < 10 && pend.size() > 0; i++) step();
    log_q.delete();
    pc    = start_pc;
    reset = 1'b1;
  endtask

  task automatic wait_adv(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = s_adv;
    end
    chk({name, "_handshake"}, seen, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    pc             = '0;
    redirect       = 1'b0;
    halt           = 1'b0;
    mem_req_ready  = 1'b1;
    instr_ready    = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // Straight-line fetch from pc 0
    lat = 2;
    do_reset(32'h0);
    run(20);
    for (int i = 0; i < 3; i++) begin
      chk("straight_pc", log_pc(i), 64'(i));
      chk("straight_data", log_data(i), 64'(32'h100 + i));
    end

    // Backpressure: decode stalled, two words queued, then released
    instr_ready = 1'b0;
    do_reset(32'h20);
    run(20);
    chk("bp_pc_steps", pc, 32'h22);
    chk("bp_req_idle", s_req_valid, 1'b0);
    chk("bp_head_valid", s_instr_valid, 1'b1);
    chk("bp_head_pc", s_instr_pc, 32'h20);
    instr_ready = 1'b1;
    run(24);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order_pc", log_pc(i), 64'(32'h20 + i));
      chk("bp_order_data", log_data(i), 64'(32'h120 + i));
    end

    // Redirect while the pc=5 request waits for its reply
    do_reset(32'h5);
    wait_adv("rw");
    redirect_tgt = 32'h40;
    redirect     = 1'b1;
    step();
    redirect = 1'b0;
    run(15);
    chk("rw_first_pc", log_pc(0), 64'h40);
    chk("rw_first_data", log_data(0), 64'h140);

    // Redirect arriving together with the reply (latency 1)
    lat = 1;
    do_reset(32'h50);
    wait_adv("rr");
    redirect_tgt = 32'h60;
    redirect     = 1'b1;
    step();
    redirect = 1'b0;
    run(12);
    chk("rr_first_pc", log_pc(0), 64'h60);
    chk("rr_first_data", log_data(0), 64'h160);

    // Redirect on the handshake cycle of pc=7
    lat = 2;
    mem_req_ready = 1'b0;
    do_reset(32'h7);
    for (int i = 0; i < 10 && !s_req_valid; i++) step();
    chk("rh_req_seen", s_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    redirect_tgt  = 32'h80;
    redirect      = 1'b1;
    step();
    chk("rh_req_valid", s_req_valid, 1'b1);
    chk("rh_no_advance", s_adv, 1'b0);
    redirect = 1'b0;
    run(20);
    chk("rh_first_pc", log_pc(0), 64'h80);
    chk("rh_first_data", log_data(0), 64'h180);

    // Halt pulse while pc=9 is in flight
    do_reset(32'h9);
    wait_adv("halt");
    halt = 1'b1;
    step();
    halt = 1'b0;
    run(15);
    chk("halt_words", 64'(log_q.size()), 64'd1);
    chk("halt_word_pc", log_pc(0), 64'h9);
    chk("halt_word_data", log_data(0), 64'h109);
    chk("halt_pc_steps", pc, 32'ha);
    chk("halt_halted", s_halted, 1'b1);

    // Reset while waiting; the stale reply must not be enqueued
    lat = 3;
    do_reset(32'h30);
    wait_adv("rst");
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_req_valid", s_req_valid, 1'b0);
    chk("rst_pc_advance", s_adv, 1'b0);
    chk("rst_instr_valid", s_instr_valid, 1'b0);
    chk("rst_instr", s_instr, 32'h0);
    chk("rst_instr_pc", s_instr_pc, 32'h0);
    chk("rst_halted", s_halted, 1'b0);
    run(15);
    chk("rst_first_pc", log_pc(0), 64'h31);
    chk("rst_first_data", log_data(0), 64'h131);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
